// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multicycle MIPS control path: opcodes, states, ALUOp codes, control bundle.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package multicycle_control_pkg;

    // Instruction opcodes (IR[31:26])
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ANDI = 6'b001100;

    // Control FSM state encodings; codes 12-15 are unused
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_REXEC  = 4'd6;
    localparam logic [3:0] S_RWB    = 4'd7;
    localparam logic [3:0] S_BEQ    = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_IEXEC  = 4'd10;
    localparam logic [3:0] S_IWB    = 4'd11;

    // ALUOp codes presented to the ALU-control decoder
    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b100;
    localparam logic [2:0] ALUOP_ANDI  = 3'b110;

    // Datapath control bundle produced by the output decoder
    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsource;
        logic [2:0] aluop;
    } ctrl_t;

    // True for every opcode the FSM knows how to sequence
    function automatic logic op_is_legal(input logic [5:0] op);
        return (op == OP_R)   || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J)  || (op == OP_ANDI);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle between the control FSM and the datapath: opcode/mem_ready in, control strobes out.
// Latency: n/a (wires only).
// Backpressure: mem_ready from memory stalls the controller in its memory states.
interface multicycle_control_if;
    import multicycle_control_pkg::*;

    logic [5:0] opcode;
    logic       mem_ready;
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsource;
    logic [2:0] aluop;
    logic       illegal_op;
    logic [3:0] state;

    // Controller side
    modport master (
        input  opcode, mem_ready,
        output pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
               memtoreg, regdst, regwrite, alusrca, alusrcb, pcsource,
               aluop, illegal_op, state
    );

    // Datapath / memory side
    modport slave (
        output opcode, mem_ready,
        input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
               memtoreg, regdst, regwrite, alusrca, alusrcb, pcsource,
               aluop, illegal_op, state
    );

endinterface

// File: rtl/multicycle_control_output_decode.sv
// Moore decode of FSM state into datapath controls; only FETCH strobes look at mem_ready.
// Latency: combinational, 0 cycles.
// Backpressure: without mem_ready, FETCH holds irwrite/pcwrite low so the PC/IR are not disturbed.
module mc_output_decode
    import multicycle_control_pkg::*;
#(
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic [3:0] state,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    logic mem_ok;

    assign mem_ok = USE_MEM_READY ? mem_ready : 1'b1;

    // Per-state control pattern; anything not set here stays 0, including unused codes
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.memread  = 1'b1;
                ctrl.alusrcb  = 2'b01;
                ctrl.aluop    = ALUOP_ADD;
                ctrl.irwrite  = mem_ok;
                ctrl.pcwrite  = mem_ok;
            end
            S_DECODE: begin
                ctrl.alusrcb  = 2'b11;
                ctrl.aluop    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alusrca  = 1'b1;
                ctrl.alusrcb  = 2'b10;
                ctrl.aluop    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.memread  = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            S_REXEC: begin
                ctrl.alusrca  = 1'b1;
                ctrl.alusrcb  = 2'b00;
                ctrl.aluop    = ALUOP_RTYPE;
            end
            S_RWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
            end
            S_BEQ: begin
                ctrl.alusrca     = 1'b1;
                ctrl.alusrcb     = 2'b00;
                ctrl.aluop       = ALUOP_SUB;
                ctrl.pcwritecond = 1'b1;
                ctrl.pcsource    = 2'b01;
            end
            S_JUMP: begin
                ctrl.pcwrite  = 1'b1;
                ctrl.pcsource = 2'b10;
            end
            S_IEXEC: begin
                ctrl.alusrca  = 1'b1;
                ctrl.alusrcb  = 2'b10;
                ctrl.aluop    = ALUOP_ANDI;
            end
            S_IWB: begin
                ctrl.regwrite = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS: fetch, decode, execute, memory, writeback.
// Latency: LW 5, SW/R/ANDI 4, BEQ/J 3 cycles with mem_ready high.
// Backpressure: FETCH, MEMRD and MEMWR hold one extra cycle per cycle mem_ready is low.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    multicycle_control_if.master  bus
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       mem_ok;
    ctrl_t      ctrl_raw;
    ctrl_t      ctrl;

    assign mem_ok = USE_MEM_READY ? bus.mem_ready : 1'b1;

    // State register; reset aborts any instruction in flight, no pending write is replayed
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Transition logic; opcode is stable from DECODE on because IR is only loaded in FETCH
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_ok ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_REXEC;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_J:         state_d = S_JUMP;
                    OP_ANDI:      state_d = S_IEXEC;
                    default:      state_d = S_FETCH;  // PC already advanced: acts as a NOP
                endcase
            end
            S_MEMADR: state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = mem_ok ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = mem_ok ? S_FETCH : S_MEMWR;
            S_REXEC:  state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_BEQ:    state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_IEXEC:  state_d = S_IWB;
            S_IWB:    state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    mc_output_decode #(
        .USE_MEM_READY (USE_MEM_READY)
    ) u_output_decode (
        .state     (state_q),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl_raw)
    );

    // All outputs, state included, read 0 while reset is held
    assign ctrl = rst_n ? ctrl_raw : '0;

    assign bus.pcwrite     = ctrl.pcwrite;
    assign bus.pcwritecond = ctrl.pcwritecond;
    assign bus.iord        = ctrl.iord;
    assign bus.memread     = ctrl.memread;
    assign bus.memwrite    = ctrl.memwrite;
    assign bus.irwrite     = ctrl.irwrite;
    assign bus.memtoreg    = ctrl.memtoreg;
    assign bus.regdst      = ctrl.regdst;
    assign bus.regwrite    = ctrl.regwrite;
    assign bus.alusrca     = ctrl.alusrca;
    assign bus.alusrcb     = ctrl.alusrcb;
    assign bus.pcsource    = ctrl.pcsource;
    assign bus.aluop       = ctrl.aluop;
    assign bus.state       = rst_n ? state_q : 4'd0;
    assign bus.illegal_op  = rst_n && (state_q == S_DECODE) && !op_is_legal(bus.opcode);

endmodule
